// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and frame constants for the I2S transmitter
package i2s_pkg;

  localparam int SAMPLE_WIDTH_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    XMIT = 1'b1
  } state_t;

  // Slot 0 is the one-bit word-select lead, followed by both channel words.
  function automatic int frame_slots(input int width);
    return 2 * width + 1;
  endfunction

  localparam int FRAME_SLOTS = frame_slots(SAMPLE_WIDTH_DEF);

endpackage

// File: rtl/i2s_controller_if.sv
// rtl/i2s_controller_if.sv - sample/request and serial I2S signals; busy exists under I2S_CONTROLLER_BUSY_EN
interface i2s_controller_if
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
);

  logic                    send;
  logic [SAMPLE_WIDTH-1:0] sample_left;
  logic [SAMPLE_WIDTH-1:0] sample_right;
  logic                    bit_clk;
  logic                    frame_clk;
  logic                    data;
`ifdef I2S_CONTROLLER_BUSY_EN
  logic                    busy;

  modport master (
    output send, sample_left, sample_right,
    input  bit_clk, frame_clk, data, busy
  );

  modport slave (
    input  send, sample_left, sample_right,
    output bit_clk, frame_clk, data, busy
  );
`else
  modport master (
    output send, sample_left, sample_right,
    input  bit_clk, frame_clk, data
  );

  modport slave (
    input  send, sample_left, sample_right,
    output bit_clk, frame_clk, data
  );
`endif

endinterface

// File: rtl/i2s_clk_div.sv
// rtl/i2s_clk_div.sv - bit clock generator with a strobe in the last cycle of every slot
module i2s_clk_div #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bit_clk,
  output logic slot_start
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          half_end;

  assign half_end = (cnt == CW'(CLK_DIV - 1));

  // High while the next clk edge opens a new slot (falling edge of bit_clk).
  assign slot_start = run & bit_clk & half_end;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt     <= '0;
      bit_clk <= 1'b0;
    end else if (half_end) begin
      cnt     <= '0;
      bit_clk <= ~bit_clk;
    end else begin
      cnt     <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2s_controller.sv
// rtl/i2s_controller.sv - one stereo frame per send; I2S_CONTROLLER_BUSY_EN adds a registered busy output
module i2s_controller
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int CLK_DIV      = 1
) (
  input  logic              clk,
  input  logic              reset,
  i2s_controller_if.slave   bus
);

  localparam int SLOTS = frame_slots(SAMPLE_WIDTH);
  localparam int SW    = $clog2(SLOTS);

  state_t                    state;
  logic [SW-1:0]             slot;
  logic [SW-1:0]             slot_nxt;
  logic [2*SAMPLE_WIDTH-1:0] shreg;
  logic                      frame_q;
  logic                      data_q;
  logic                      bit_clk;
  logic                      slot_start;
`ifdef I2S_CONTROLLER_BUSY_EN
  logic                      busy_q;
  assign bus.busy = busy_q;
`endif

  assign slot_nxt      = slot + SW'(1);
  assign bus.bit_clk   = bit_clk;
  assign bus.frame_clk = frame_q;
  assign bus.data      = data_q;

  i2s_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk       (clk),
    .reset     (reset),
    .run       (state == XMIT),
    .bit_clk   (bit_clk),
    .slot_start(slot_start)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      slot    <= '0;
      shreg   <= '0;
      frame_q <= 1'b0;
      data_q  <= 1'b0;
`ifdef I2S_CONTROLLER_BUSY_EN
      busy_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          slot    <= '0;
          frame_q <= 1'b0;
          data_q  <= 1'b0;
          if (bus.send) begin
            shreg <= {bus.sample_left, bus.sample_right};
            state <= XMIT;
`ifdef I2S_CONTROLLER_BUSY_EN
            busy_q <= 1'b1;
`endif
          end
        end
        XMIT: begin
          if (slot_start) begin
            if (slot == SW'(SLOTS - 1)) begin
              state   <= IDLE;
              slot    <= '0;
              shreg   <= '0;
              frame_q <= 1'b0;
              data_q  <= 1'b0;
`ifdef I2S_CONTROLLER_BUSY_EN
              busy_q  <= 1'b0;
`endif
            end else begin
              // Word select leads the data by one slot, so it flips at the channel's last bit.
              slot    <= slot_nxt;
              data_q  <= shreg[2*SAMPLE_WIDTH-1];
              shreg   <= {shreg[2*SAMPLE_WIDTH-2:0], 1'b0};
              frame_q <= (slot_nxt >= SW'(SAMPLE_WIDTH)) && (slot_nxt < SW'(2 * SAMPLE_WIDTH));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_controller.sv
// tb/tb_i2s_controller.sv - directed frame vectors for i2s_controller at CLK_DIV 1 and 4
module tb_i2s_controller;
  import i2s_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

`ifdef I2S_CONTROLLER_BUSY_EN
  localparam logic BUSY_ON = 1'b1;
`else
  localparam logic BUSY_ON = 1'b0;
`endif

  i2s_controller_if #(.SAMPLE_WIDTH(16)) bus1 ();
  i2s_controller_if #(.SAMPLE_WIDTH(16)) bus4 ();

  i2s_controller #(.SAMPLE_WIDTH(16), .CLK_DIV(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));
  i2s_controller #(.SAMPLE_WIDTH(16), .CLK_DIV(4)) u4 (.clk(clk), .reset(reset), .bus(bus4));

  typedef struct {
    int          d;
    logic [15:0] l;
    logic [15:0] r;
    bit          disturb;
    logic [31:0] exp_word;
    int          exp_len;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic s, input logic [15:0] l, input logic [15:0] r);
    if (d == 1) begin
      bus1.send = s; bus1.sample_left = l; bus1.sample_right = r;
    end else begin
      bus4.send = s; bus4.sample_left = l; bus4.sample_right = r;
    end
  endtask

  // {bit_clk, frame_clk, data, busy}
  function automatic logic [3:0] outs(input int d);
    logic b;
    b = 1'b0;
    if (d == 1) begin
`ifdef I2S_CONTROLLER_BUSY_EN
      b = bus1.busy;
`endif
      return {bus1.bit_clk, bus1.frame_clk, bus1.data, b};
    end
`ifdef I2S_CONTROLLER_BUSY_EN
    b = bus4.busy;
`endif
    return {bus4.bit_clk, bus4.frame_clk, bus4.data, b};
  endfunction

  // Expected outputs c cycles after the edge that accepted send.
  function automatic logic [3:0] model(input int d, input int c, input logic [31:0] w);
    int   s;
    logic b, f, dt;
    s  = c / (2 * d);
    b  = (c % (2 * d)) >= d;
    f  = (s >= 16) && (s <= 31);
    dt = (s == 0) ? 1'b0 : w[32 - s];
    return {b, f, dt, BUSY_ON};
  endfunction

  task automatic run_frame(input vec_t v, input string name);
    int         bad, rises, last_hi;
    logic       prev;
    logic [31:0] word;
    logic [3:0] o, e;
    bad = 0; rises = 0; last_hi = 0; prev = 1'b0; word = '0;
    drive(v.d, 1'b1, v.l, v.r);
    @(posedge clk); #1;
    drive(v.d, 1'b0, v.l, v.r);
    for (int c = 0; c < v.exp_len + 4; c++) begin
      if (v.disturb && c == 20) drive(v.d, 1'b1, ~v.l, ~v.r);
      if (v.disturb && c == 24) drive(v.d, 1'b0, ~v.l, ~v.r);
      o = outs(v.d);
      e = (c < v.exp_len) ? model(v.d, c, v.exp_word) : 4'b0000;
      if (o !== e) bad++;
      if (o[3] && !prev) begin
        rises++;
        if (rises > 1) word = {word[30:0], o[1]};
      end
      if (o[3]) last_hi = c + 1;
      prev = o[3];
      @(posedge clk); #1;
    end
    check({name, " cycle errors"}, bad, 0);
    check({name, " word"}, word, v.exp_word);
    check({name, " bit_clk rises"}, rises, 33);
    check({name, " frame length"}, last_hi, v.exp_len);
  endtask

  initial begin
    int bad;
    logic [3:0] o, e;

    vecs[0] = '{1, 16'h0011, 16'h0011, 1'b0, 32'h0011_0011, 66};
    vecs[1] = '{1, 16'h8000, 16'h0001, 1'b0, 32'h8000_0001, 66};
    vecs[2] = '{1, 16'hFFFF, 16'h0000, 1'b0, 32'hFFFF_0000, 66};
    vecs[3] = '{1, 16'h1234, 16'hABCD, 1'b1, 32'h1234_ABCD, 66};
    vecs[4] = '{4, 16'h8000, 16'h0001, 1'b0, 32'h8000_0001, 264};
    vecs[5] = '{4, 16'hC3A5, 16'h5A3C, 1'b1, 32'hC3A5_5A3C, 264};

    drive(1, 1'b0, 16'h0, 16'h0);
    drive(4, 1'b0, 16'h0, 16'h0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("in reset dut1", outs(1), 4'b0000);
    check("in reset dut4", outs(4), 4'b0000);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (outs(1) !== 4'b0000) bad++;
      if (outs(4) !== 4'b0000) bad++;
    end
    check("idle without send", bad, 0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // send held high: 66-cycle frames separated by exactly one idle cycle
    bad = 0;
    drive(1, 1'b1, 16'hA5F0, 16'h0F5A);
    @(posedge clk); #1;
    for (int c = 0; c < 137; c++) begin
      if (c < 134) e = ((c % 67) < 66) ? model(1, c % 67, 32'hA5F0_0F5A) : 4'b0000;
      else e = 4'b0000;
      o = outs(1);
      if (o !== e) bad++;
      if (c == 133) drive(1, 1'b0, 16'hA5F0, 16'h0F5A);
      @(posedge clk); #1;
    end
    check("held send back-to-back", bad, 0);

    // reset during slot 10 aborts the frame on the next edge
    drive(1, 1'b1, 16'hFFFF, 16'hFFFF);
    @(posedge clk); #1;
    drive(1, 1'b0, 16'hFFFF, 16'hFFFF);
    for (int c = 0; c < 21; c++) begin
      @(posedge clk); #1;
    end
    check("slot 10 before reset", outs(1), model(1, 21, 32'hFFFF_FFFF));
    reset = 1'b1;
    @(posedge clk); #1;
    check("outputs after mid-frame reset", outs(1), 4'b0000);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (outs(1) !== 4'b0000) bad++;
    end
    check("idle after aborted frame", bad, 0);
    run_frame(vecs[1], "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_controller.md
Name: i2s_controller

Overview:
- I2S transmitter that serialises one stereo frame (16-bit left, 16-bit right) per `send` request.
- Generates bit clock (`bit_clk`), word-select (`frame_clk`) and serial `data` from the single system clock.
- Sits between the synth sample source and an external I2S DAC.
- Fully synchronous; all outputs are registered.

Parameters:
- SAMPLE_WIDTH, 16, bits per channel sample.
- CLK_DIV, 1, system-clock cycles per `bit_clk` half-period (≥1).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- send  input  1  start-of-frame request, sampled only in IDLE
- sample_left  input  SAMPLE_WIDTH  left-channel sample, two's complement
- sample_right  input  SAMPLE_WIDTH  right-channel sample, two's complement
- bit_clk  output  1  I2S serial bit clock
- frame_clk  output  1  I2S word select (0 = left, 1 = right)
- data  output  1  I2S serial data, MSB first

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - `bit_clk`, `frame_clk` and `data` go to 0.
  - State goes to IDLE; the shift register and counters clear.
  - Reset mid-frame aborts the frame immediately; no partial completion.
- States: IDLE, XMIT.
- IDLE: outputs held at 0.
  - `send`=1 at a clk edge latches {sample_left, sample_right} into a 2*SAMPLE_WIDTH shift register, left MSB at the top.
  - The same edge enters XMIT at slot 0.
- XMIT: a frame is 2*SAMPLE_WIDTH+1 slots (33 by default), numbered 0..32.
  - Each slot lasts 2*CLK_DIV clk cycles: `bit_clk`=0 for the first CLK_DIV cycles, 1 for the next CLK_DIV.
  - `frame_clk` and `data` change only on the edge that begins a slot, i.e. the falling edge of `bit_clk`. The DAC samples on the `bit_clk` rising edge.
  - `frame_clk` is 0 in slots 0..15, 1 in slots 16..31, and 0 in slot 32 (standard I2S one-bit WS lead).
  - `data` in slot 0 is 0. In slot k (1..32) it is shift-register bit (31-(k-1)).
    - Slot 1 carries left[15], slot 16 left[0], slot 17 right[15], slot 32 right[0].
- Latency: first slot's outputs are visible the cycle after `send` is sampled.
  - Whole frame = (2*SAMPLE_WIDTH+1)*2*CLK_DIV cycles, which is 66 with defaults.
- End of slot 32: return to IDLE, outputs 0.
  - IDLE lasts at least one cycle, so back-to-back frames are separated by ≥1 idle clk.
  - `send` held high starts the next frame after that cycle.
- `send` during XMIT is ignored and not queued. Samples latched at start are unaffected by later input changes.
- Counters: divider counter 0..CLK_DIV-1; slot counter 0..32 (6 bits); both wrap to 0 on frame end.

Optional Feature:
- Macro I2S_CONTROLLER_BUSY_EN.
- Defined: adds output port `busy` (1 bit), registered.
  - Reads 1 in every XMIT cycle and 0 in IDLE and under reset.
  - Rises the cycle after `send` is accepted; falls on the return to IDLE.
- Undefined: port absent; behaviour otherwise identical.

Decomposition:
- Shared package `i2s_pkg` holds:
  - SAMPLE_WIDTH default
  - state enum type (IDLE, XMIT)
  - FRAME_SLOTS constant = 2*SAMPLE_WIDTH+1
- One natural sub-module, `i2s_clk_div`:
  - Generates `bit_clk` and a one-cycle slot-start strobe from CLK_DIV.
  - Resets with the parent.

Test Plan:
- Reset pulse then idle 10 cycles -> `bit_clk`=`frame_clk`=`data`=0 throughout; no activity without `send`.
- left=17, right=17, one-cycle `send`, CLK_DIV=1 -> 33 `bit_clk` periods.
  - `data` sampled on `bit_clk` rising edge reads 0, then 0x0011, then 0x0011, MSB first.
  - `frame_clk` 0 for slots 0-15, 1 for 16-31, 0 at 32; then idle.
- left=0x8000, right=0x0001 -> `data`=1 only in slot 1 and slot 32; frame length 66 clk.
- `send` re-pulsed mid-frame and sample inputs changed mid-frame -> ignored; frame carries the originally latched values, no second frame.
- `send` held high continuously -> consecutive frames separated by exactly one idle clk.
- Reset asserted in slot 10 -> all outputs 0 next edge; new `send` afterwards produces a complete correct frame.
- CLK_DIV=4 -> `bit_clk` period 8 clk; slot timing scales accordingly.
